// File: rtl/alephminer_axi_write_master.sv
// rtl/alephminer_axi_write_master.sv - AXI4 INCR-burst write master draining a result FIFO
// Optional bresp error flag: define ALEPHMINER_AXI_WR_BRESP_CHECK_EN
module alephminer_axi_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = C_M_AXI_ADDR_WIDTH,
    parameter int C_FIFO_DEPTH       = 256
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_start,
    output logic                            ctrl_done,
    output logic                            ctrl_error,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
    input  logic                            Vld_I,
    output logic                            Rdy_O,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   Data_I,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic [1:0]                      m_axi_bresp
);
    localparam int LP_BYTES         = C_M_AXI_DATA_WIDTH / 8;
    localparam int LP_BYTE_SHIFT    = $clog2(LP_BYTES);
    localparam int LP_AXI_BURST_LEN = (4096 / LP_BYTES < 256) ? 4096 / LP_BYTES : 256;
    localparam int LP_PTR_W         = $clog2(C_FIFO_DEPTH);
    localparam int LP_CNT_W         = LP_PTR_W + 1;
    localparam int LP_XW1           = C_XFER_SIZE_WIDTH + 1;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LP_ADDR_MASK =
        ~C_M_AXI_ADDR_WIDTH'(LP_AXI_BURST_LEN * LP_BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AW, S_W, S_B, S_DONE} state_t;

    logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [LP_PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [LP_CNT_W-1:0]           count, count_nxt;
    logic                          rdy_q, push, pop;

    state_t                        state, state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [C_XFER_SIZE_WIDTH-1:0]  beats_rem, beats_rem_nxt, beats_left, beats_init;
    logic [LP_XW1-1:0]             size_round;
    logic [7:0]                    burst_m1, burst_m1_nxt, beat_cnt, beat_cnt_nxt;
    logic [8:0]                    burst;

    function automatic logic [7:0] calc_burst_m1(input logic [C_XFER_SIZE_WIDTH-1:0] beats);
        if (beats >= C_XFER_SIZE_WIDTH'(LP_AXI_BURST_LEN))
            return 8'(LP_AXI_BURST_LEN - 1);
        else
            return 8'(beats - 1'b1);
    endfunction

    // Ready is registered from the next count so it is 0 while reset is held.
    assign Rdy_O = rdy_q;
    assign push  = Vld_I & rdy_q;
    assign pop   = m_axi_wvalid & m_axi_wready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            rdy_q <= (count_nxt != LP_CNT_W'(C_FIFO_DEPTH));
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= Data_I;
    end

    assign size_round = {1'b0, ctrl_xfer_size_in_bytes} + LP_XW1'(LP_BYTES - 1);
    assign beats_init = C_XFER_SIZE_WIDTH'(size_round >> LP_BYTE_SHIFT);
    assign burst      = {1'b0, burst_m1} + 9'd1;
    assign beats_left = beats_rem - C_XFER_SIZE_WIDTH'(burst);

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        beats_rem_nxt = beats_rem;
        burst_m1_nxt  = burst_m1;
        beat_cnt_nxt  = beat_cnt;
        unique case (state)
            S_IDLE: if (ctrl_start) begin
                state_nxt     = S_SETUP;
                addr_nxt      = ctrl_addr_offset & LP_ADDR_MASK;
                beats_rem_nxt = beats_init;
            end
            S_SETUP: if (beats_rem == '0) begin
                state_nxt = S_DONE;
            end else begin
                burst_m1_nxt = calc_burst_m1(beats_rem);
                state_nxt    = S_AW;
            end
            S_AW: if (m_axi_awvalid && m_axi_awready) begin
                beat_cnt_nxt = '0;
                state_nxt    = S_W;
            end
            S_W: if (pop) begin
                beat_cnt_nxt = beat_cnt + 1'b1;
                if (m_axi_wlast) state_nxt = S_B;
            end
            S_B: if (m_axi_bvalid) begin
                beats_rem_nxt = beats_left;
                addr_nxt      = addr + (C_M_AXI_ADDR_WIDTH'(burst) << LP_BYTE_SHIFT);
                if (beats_left == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    burst_m1_nxt = calc_burst_m1(beats_left);
                    state_nxt    = S_AW;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state     <= S_IDLE;
            addr      <= '0;
            beats_rem <= '0;
            burst_m1  <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            beats_rem <= beats_rem_nxt;
            burst_m1  <= burst_m1_nxt;
            beat_cnt  <= beat_cnt_nxt;
        end
    end

    // AW waits for a full burst in the FIFO; count cannot drop in AW, so awvalid stays up.
    assign m_axi_awvalid = (state == S_AW) && (32'(count) >= 32'(burst));
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = burst_m1;
    assign m_axi_wvalid  = (state == S_W) && (count != '0);
    assign m_axi_wdata   = mem[rd_ptr];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state == S_W) && (beat_cnt == burst_m1);
    assign m_axi_bready  = (state == S_B);
    assign ctrl_done     = (state == S_DONE);

`ifdef ALEPHMINER_AXI_WR_BRESP_CHECK_EN
    logic error_q;
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset)
            error_q <= 1'b0;
        else if (state == S_IDLE && ctrl_start)
            error_q <= 1'b0;
        else if (m_axi_bvalid && m_axi_bready && m_axi_bresp[1])
            error_q <= 1'b1;
    end
    assign ctrl_error = error_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp;
    assign ctrl_error   = 1'b0;
`endif
endmodule

// File: tb/tb_alephminer_axi_write_master.sv
// tb/tb_alephminer_axi_write_master.sv - scoreboard bench for the AXI write master
module tb_alephminer_axi_write_master;
    localparam int AW = 64;
    localparam int DW = 32;

    logic aclk = 1'b0, areset = 1'b0;
    logic ctrl_start = 1'b0, ctrl_done, ctrl_error;
    logic [AW-1:0] ctrl_addr_offset = '0, ctrl_xfer_size_in_bytes = '0;
    logic Vld_I = 1'b0, Rdy_O;
    logic [DW-1:0] Data_I = '0;
    logic m_axi_awvalid, m_axi_awready = 1'b0;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0] m_axi_awlen;
    logic m_axi_wvalid, m_axi_wready = 1'b0, m_axi_wlast;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic m_axi_bvalid = 1'b0, m_axi_bready;
    logic [1:0] m_axi_bresp = 2'b00;

    int errors = 0, checks = 0;
    logic [DW-1:0] exp_data[$];
    logic [AW+7:0] exp_aw[$];
    int feed_left = 0;
    logic [DW-1:0] feed_seq = '0;
    bit stall = 0, b_pend = 0, burst_open = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int beat = 0, aw_hs = 0, w_hs = 0, done_cnt = 0;
    logic [7:0] cur_len = '0;
    logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
    logic [AW+7:0] prev_aw = '0;
    logic [DW-1:0] prev_wd = '0;
    int base_aw, base_w;

    alephminer_axi_write_master dut (
        .aclk(aclk), .areset(areset),
        .ctrl_start(ctrl_start), .ctrl_done(ctrl_done), .ctrl_error(ctrl_error),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .Vld_I(Vld_I), .Rdy_O(Rdy_O), .Data_I(Data_I),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result word source; every accepted word goes onto the scoreboard.
    always @(negedge aclk) begin
        if (feed_left > 0 && areset) begin
            Vld_I  = 1'b1;
            Data_I = 32'hA500_0000 ^ feed_seq;
        end else begin
            Vld_I = 1'b0;
        end
        #1;
        if (Vld_I && Rdy_O && areset) begin
            exp_data.push_back(Data_I);
            feed_seq++;
            feed_left--;
        end
    end

    // Memory slave plus channel monitor.
    always @(negedge aclk) begin
        m_axi_awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_bvalid  = b_pend && (!stall || $urandom_range(0, 1) == 1);
        m_axi_bresp   = m_axi_bvalid ? bresp_cfg : 2'b00;
        #1;
        if (!areset) begin
            prev_awv = 0;
            prev_wv  = 0;
        end else begin
            if (ctrl_done) done_cnt++;
            if (prev_awv && !prev_awr) begin
                check("aw_hold_valid", m_axi_awvalid, 1);
                check("aw_hold_addr_len", {m_axi_awaddr, m_axi_awlen}, prev_aw);
            end
            if (prev_wv && !prev_wr) begin
                check("w_hold_valid", m_axi_wvalid, 1);
                check("w_hold_data", m_axi_wdata, prev_wd);
            end
            if (m_axi_awvalid && m_axi_awready) begin
                check("aw_only_after_b", burst_open, 0);
                check("aw_expected", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0)
                    check("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, exp_aw.pop_front());
                cur_len    = m_axi_awlen;
                beat       = 0;
                burst_open = 1;
                aw_hs++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("w_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0)
                    check("wdata", m_axi_wdata, exp_data.pop_front());
                check("wlast", m_axi_wlast, beat == int'(cur_len));
                check("wstrb", m_axi_wstrb, 4'hF);
                beat++;
                w_hs++;
                if (m_axi_wlast) b_pend = 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend     = 0;
                burst_open = 0;
            end
            prev_awv = m_axi_awvalid;
            prev_awr = m_axi_awready;
            prev_aw  = {m_axi_awaddr, m_axi_awlen};
            prev_wv  = m_axi_wvalid;
            prev_wr  = m_axi_wready;
            prev_wd  = m_axi_wdata;
        end
    end

    task automatic start_xfer(input logic [AW-1:0] off, input logic [AW-1:0] size);
        logic [AW-1:0] a;
        longint unsigned beats, b;
        beats = (size + 3) / 4;
        a = off & ~64'h3FF;
        while (beats > 0) begin
            b = (beats > 256) ? 256 : beats;
            exp_aw.push_back({a, 8'(b - 1)});
            a += 64'(b * 4);
            beats -= b;
        end
        @(negedge aclk);
        ctrl_start = 1'b1;
        ctrl_addr_offset = off;
        ctrl_xfer_size_in_bytes = size;
        @(negedge aclk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge aclk);
            n++;
        end
        check(tag, done_cnt >= target, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge aclk);
        #2;
        check("rst_rdy", Rdy_O, 0);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast}, 4'b0);
        check("rst_ctrl", {ctrl_done, ctrl_error}, 2'b0);
        check("rst_aw", {m_axi_awaddr, m_axi_awlen}, 72'h0);
        @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        #2;
        check("idle_rdy", Rdy_O, 1);
        check("idle_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, ctrl_done}, 4'b0);

        // Single 16-byte burst from an unaligned offset
        feed_left = 4;
        repeat (6) @(negedge aclk);
        #2;
        base_aw = aw_hs; base_w = w_hs;
        start_xfer(64'h1234, 64'd16);
        wait_done(1, 200, "t1_done");
        repeat (5) @(negedge aclk);
        #2;
        check("t1_done_once", done_cnt, 1);
        check("t1_aw_count", aw_hs - base_aw, 1);
        check("t1_w_count", w_hs - base_w, 4);
        check("t1_queues_empty", exp_aw.size() + exp_data.size(), 0);

        // 4100 bytes: four full bursts and a one-beat tail, FIFO fed continuously
        base_aw = aw_hs; base_w = w_hs;
        feed_left = 1025;
        start_xfer(64'h0, 64'd4100);
        wait_done(2, 5000, "t2_done");
        repeat (5) @(negedge aclk);
        #2;
        check("t2_done_once", done_cnt, 2);
        check("t2_aw_count", aw_hs - base_aw, 5);
        check("t2_w_count", w_hs - base_w, 1025);
        check("t2_queues_empty", exp_aw.size() + exp_data.size(), 0);

        // Zero-length transfer: done two cycles after start, no bus activity
        base_aw = aw_hs; base_w = w_hs;
        @(negedge aclk);
        ctrl_start = 1'b1;
        ctrl_addr_offset = 64'h500;
        ctrl_xfer_size_in_bytes = 64'd0;
        @(negedge aclk);
        ctrl_start = 1'b0;
        #2;
        check("t3_done_c1", ctrl_done, 0);
        @(negedge aclk);
        #2;
        check("t3_done_c2", ctrl_done, 1);
        @(negedge aclk);
        #2;
        check("t3_done_c3", ctrl_done, 0);
        check("t3_no_bus", (aw_hs - base_aw) + (w_hs - base_w), 0);

        // AW held back until the FIFO holds the whole burst; random back-pressure
        stall = 1;
        base_aw = aw_hs; base_w = w_hs;
        feed_left = 3;
        repeat (8) @(negedge aclk);
        #2;
        start_xfer(64'h40, 64'd16);
        repeat (8) @(negedge aclk);
        #2;
        check("t4_aw_wait", m_axi_awvalid, 0);
        @(posedge aclk);
        #1;
        feed_left = 1;
        @(negedge aclk);
        #2;
        check("t4_aw_still_low", m_axi_awvalid, 0);
        @(negedge aclk);
        #2;
        check("t4_aw_rises", m_axi_awvalid, 1);
        wait_done(4, 500, "t4_done");
        check("t4_w_count", w_hs - base_w, 4);
        stall = 0;

        // Two bursts answered with SLVERR
        bresp_cfg = 2'b10;
        feed_left = 512;
        start_xfer(64'h2000, 64'd2048);
        wait_done(5, 3000, "t5_done");
`ifdef ALEPHMINER_AXI_WR_BRESP_CHECK_EN
        check("t5_error_set", ctrl_error, 1);
`else
        check("t5_error_tied", ctrl_error, 0);
`endif
        bresp_cfg = 2'b00;
        start_xfer(64'h0, 64'd0);
        #2;
        check("t5_error_cleared", ctrl_error, 0);
        wait_done(6, 50, "t5_done2");

        // Asynchronous reset in the middle of a write burst
        stall = 1;
        base_w = w_hs;
        feed_left = 16;
        start_xfer(64'h3000, 64'd64);
        for (int n = 0; n < 500 && (w_hs - base_w) < 3; n++) @(posedge aclk);
        check("t6_mid_burst", (w_hs - base_w) >= 3 && (w_hs - base_w) < 16, 1);
        @(posedge aclk);
        #2;
        areset = 1'b0;
        #1;
        check("t6_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast}, 4'b0);
        check("t6_rst_ctrl", {ctrl_done, ctrl_error, Rdy_O}, 3'b0);
        check("t6_rst_aw", {m_axi_awaddr, m_axi_awlen}, 72'h0);
        exp_aw.delete();
        exp_data.delete();
        feed_left = 0;
        b_pend = 0;
        burst_open = 0;
        stall = 0;
        repeat (2) @(negedge aclk);
        #2;
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        #2;
        check("t6_rdy_after_release", Rdy_O, 1);
        base_aw = aw_hs; base_w = w_hs;
        start_xfer(64'h3010, 64'd16);
        repeat (5) @(negedge aclk);
        #2;
        check("t6_fifo_emptied", m_axi_awvalid, 0);
        feed_left = 4;
        wait_done(7, 300, "t6_done");
        repeat (3) @(negedge aclk);
        #2;
        check("t6_aw_count", aw_hs - base_aw, 1);
        check("t6_w_count", w_hs - base_w, 4);
        check("t6_queues_empty", exp_aw.size() + exp_data.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
